output_arbiter: RTL

OUTPUT_ARBITER -- requirements
Module: output_arbiter

---
 rtl/router_pkg.sv | 24 ++
 rtl/rr_pick.sv | 27 ++
 rtl/output_arbiter.sv | 101 ++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared router definitions: default sizes, arbiter FSM states and header field helpers.
package router_pkg;

  localparam int NPORT_DEF = 4;
  localparam int W_DEF     = 64;
  localparam int LEN_W_DEF = 8;

  localparam int MAX_W     = 512;
  localparam int MAX_LEN_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_t;

  // Returns the payload length carried in the low len_w bits of a header flit.
  function automatic logic [MAX_LEN_W-1:0] hdr_len(input logic [MAX_W-1:0] hdr, input int len_w);
    hdr_len = '0;
    for (int i = 0; i < MAX_LEN_W; i++) begin
      if (i < len_w) hdr_len[i] = hdr[i];
    end
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin selector: one-hot pick of the first requester after 'last', wrapping around.
module rr_pick
#(
  parameter int NPORT = 4,
  parameter int IDX_W = (NPORT > 1) ? $clog2(NPORT) : 1
)(
  input  logic [NPORT-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic [NPORT-1:0] pick
);

  always_comb begin
    int   idx;
    logic found;
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NPORT; k++) begin
      idx = (int'(last) + k) % NPORT;
      if (!found && req[IDX_W'(idx)]) begin
        pick[IDX_W'(idx)] = 1'b1;
        found             = 1'b1;
      end
    end
  end

endmodule

// File: rtl/output_arbiter.sv
// Packet-level output arbiter: round-robin grant to one requester, which then owns the
// output until the tail flit of its packet has been accepted.
module output_arbiter
  import router_pkg::*;
#(
  parameter int NPORT = NPORT_DEF,
  parameter int W     = W_DEF,
  parameter int LEN_W = LEN_W_DEF
)(
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [NPORT-1:0][W-1:0] D,
  input  logic [NPORT-1:0]      D_VALID,
  output logic [NPORT-1:0]      D_BP,
  output logic [W-1:0]          Q,
  output logic                  Q_VALID,
  output logic                  Q_SOF,
  input  logic                  Q_BP,
  output logic [NPORT-1:0]      GRANT
);

  localparam int IDX_W = (NPORT > 1) ? $clog2(NPORT) : 1;

  arb_state_t       state, state_nxt;
  logic [IDX_W-1:0] last_winner;
  logic [IDX_W-1:0] g_idx;
  logic [IDX_W-1:0] pick_idx;
  logic [NPORT-1:0] pick;
  logic [LEN_W-1:0] remain;
  logic [LEN_W-1:0] hdr_len_v;
  logic             first_flit;
  logic [W-1:0]     d_sel;
  logic             accept;
  logic             tail;

  rr_pick #(.NPORT(NPORT), .IDX_W(IDX_W)) u_rr_pick (
    .req  (D_VALID),
    .last (last_winner),
    .pick (pick)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NPORT; i++) begin
      if (pick[i]) pick_idx = IDX_W'(i);
    end
  end

  assign d_sel     = D[g_idx];
  assign hdr_len_v = LEN_W'(hdr_len(MAX_W'(d_sel), LEN_W));
  assign accept    = (state == XFER) && D_VALID[g_idx] && !Q_BP;
  // Tail is the header itself for empty packets, else the payload seen with one flit left.
  assign tail      = accept && (first_flit ? (hdr_len_v == '0) : (remain == LEN_W'(1)));

  always_comb begin
    D_BP      = '1;
    state_nxt = state;
    if (RST_N && state == XFER) D_BP[g_idx] = Q_BP;
    case (state)
      IDLE:    if (|D_VALID) state_nxt = XFER;
      XFER:    if (tail)     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state       <= IDLE;
      GRANT       <= '0;
      g_idx       <= '0;
      remain      <= '0;
      first_flit  <= 1'b0;
      last_winner <= IDX_W'(NPORT - 1);
      Q           <= '0;
      Q_VALID     <= 1'b0;
      Q_SOF       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && |D_VALID) begin
        GRANT      <= pick;
        g_idx      <= pick_idx;
        first_flit <= 1'b1;
      end
      if (accept) begin
        first_flit <= 1'b0;
        remain     <= first_flit ? hdr_len_v : remain - LEN_W'(1);
      end
      if (tail) begin
        GRANT       <= '0;
        last_winner <= g_idx;
      end
      // A stalled output keeps its flit and flags until downstream takes it.
      if (!Q_BP) begin
        Q_VALID <= accept;
        Q_SOF   <= accept && first_flit;
        if (accept) Q <= d_sel;
      end
    end
  end

endmodule
